dly_lock_ctrl: RTL and testbench

Closed-loop controller that produces the 8-bit delay select code for the fine64/coarse4 delay line (bits [7:6] coarse, [5:0] fine). A phase detector compares the delayed output against a reference edge. This block first runs an 8-step successive-approximation (SAR) search on the code, then switches to up/down tracking and asserts lock once the loop dithers around its operating point. It sits in the digital clock domain and drives `i_dly_sel` of the delay line directly.

---
 rtl/dly_lock_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dly_lock_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dly_lock_ctrl.sv
// Delay-line lock controller: SAR search of the 8-bit delay select code, then
// up/down tracking with lock asserted after a run of direction reversals.
module dly_lock_ctrl #(
  parameter int P_SETTLE   = 4,
  parameter int P_LOCK_CNT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_start,
  input  logic       i_pd_late,
  output logic [7:0] o_dly_sel,
  output logic       o_busy,
  output logic       o_lock,
  output logic       o_sat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAR   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(P_SETTLE);
  localparam logic [3:0] LOCK_TGT    = 4'(P_LOCK_CNT);

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] rev_q, rev_d;
  logic       dir_up_q, dir_up_d;
  logic       has_dir_q, has_dir_d;
  logic       busy_q, busy_d;
  logic       lock_q, lock_d;
  logic       sat_q, sat_d;

  logic       sample_s;
  logic       step_up_s;
  logic       blocked_s;
  logic       reversal_s;

  // Resolve SAR bit b from the detector, then arm the next lower bit as the trial.
  function automatic logic [7:0] sar_decide(input logic [7:0] code,
                                            input logic [2:0] b,
                                            input logic       late);
    logic [7:0] mask;
    logic [7:0] res;
    mask = 8'd1 << b;
    res  = late ? (code & ~mask) : code;
    if (b != 3'd0) begin
      res = res | (mask >> 1);
    end
    return res;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      code_q    <= 8'h00;
      bit_q     <= 3'd0;
      settle_q  <= 4'd0;
      rev_q     <= 4'd0;
      dir_up_q  <= 1'b0;
      has_dir_q <= 1'b0;
      busy_q    <= 1'b0;
      lock_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      bit_q     <= bit_d;
      settle_q  <= settle_d;
      rev_q     <= rev_d;
      dir_up_q  <= dir_up_d;
      has_dir_q <= has_dir_d;
      busy_q    <= busy_d;
      lock_q    <= lock_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    bit_d     = bit_q;
    settle_d  = settle_q;
    rev_d     = rev_q;
    dir_up_d  = dir_up_q;
    has_dir_d = has_dir_q;
    busy_d    = busy_q;
    lock_d    = lock_q;
    sat_d     = sat_q;

    // The detector is only trusted on the last cycle of a settle window.
    sample_s   = (settle_q == SETTLE_LAST);
    step_up_s  = ~i_pd_late;
    blocked_s  = step_up_s ? (code_q == 8'hFF) : (code_q == 8'h00);
    reversal_s = has_dir_q && (dir_up_q != step_up_s);

    if (!i_en) begin
      state_d   = ST_IDLE;
      bit_d     = 3'd0;
      settle_d  = 4'd0;
      rev_d     = 4'd0;
      dir_up_d  = 1'b0;
      has_dir_d = 1'b0;
      busy_d    = 1'b0;
      lock_d    = 1'b0;
      sat_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d  = ST_SAR;
            code_d   = 8'h80;
            bit_d    = 3'd7;
            settle_d = 4'd0;
            busy_d   = 1'b1;
          end else begin
            settle_d = 4'd0;
          end
        end
        ST_SAR: begin
          if (sample_s) begin
            code_d   = sar_decide(code_q, bit_q, i_pd_late);
            settle_d = 4'd0;
            if (bit_q == 3'd0) begin
              state_d   = ST_TRACK;
              has_dir_d = 1'b0;
              rev_d     = 4'd0;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        ST_TRACK: begin
          if (sample_s) begin
            settle_d  = 4'd0;
            dir_up_d  = step_up_s;
            has_dir_d = 1'b1;
            if (blocked_s) begin
              sat_d = 1'b1;
              rev_d = 4'd0;
            end else begin
              code_d = step_up_s ? (code_q + 8'd1) : (code_q - 8'd1);
              sat_d  = 1'b0;
              // The very first tracking step has no predecessor to reverse.
              if (reversal_s) begin
                rev_d = (rev_q == LOCK_TGT) ? rev_q : (rev_q + 4'd1);
              end else if (has_dir_q) begin
                rev_d = 4'd0;
              end else begin
                rev_d = rev_q;
              end
            end
            lock_d = (rev_d == LOCK_TGT);
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          settle_d = 4'd0;
          busy_d   = 1'b0;
          lock_d   = 1'b0;
          sat_d    = 1'b0;
        end
      endcase
    end
  end

  assign o_dly_sel = code_q;
  assign o_busy    = busy_q;
  assign o_lock    = lock_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_dly_lock_ctrl.sv
// Scoreboard bench for dly_lock_ctrl: a trial-level reference model pushes the
// expected outputs per cycle; a monitor pops and compares after every edge.
module tb_dly_lock_ctrl;

  localparam int P_SETTLE   = 4;
  localparam int P_LOCK_CNT = 4;

  logic       i_clk;
  logic       i_rst;
  logic       i_en;
  logic       i_start;
  logic       i_pd_late;
  logic [7:0] o_dly_sel;
  logic       o_busy;
  logic       o_lock;
  logic       o_sat;

  dly_lock_ctrl #(.P_SETTLE(P_SETTLE), .P_LOCK_CNT(P_LOCK_CNT)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_start  (i_start),
    .i_pd_late(i_pd_late),
    .o_dly_sel(o_dly_sel),
    .o_busy   (o_busy),
    .o_lock   (o_lock),
    .o_sat    (o_sat)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       busy;
    logic       lock;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   done    = 1'b0;

  // Reference model state (trial level)
  int tgt;
  int m_code;
  int run;
  bit m_lock, m_sat, has_prev, prev_up;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: one expectation per clock edge, sampled 2 time units after it.
  always @(posedge i_clk) begin
    #2;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if ({o_dly_sel, o_busy, o_lock, o_sat} !== mon_e) begin
        n_fail++;
        $display("FAIL cyc%0d outputs: got code=%h busy=%b lock=%b sat=%b, want code=%h busy=%b lock=%b sat=%b",
                 cyc, o_dly_sel, o_busy, o_lock, o_sat, mon_e.code, mon_e.busy, mon_e.lock, mon_e.sat);
      end
    end
  end

  // Watchdog: the scenario must complete within a bounded number of cycles.
  initial begin
    #200000;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: scenario did not complete within the wait budget");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else begin
      n_tests++;
    end
  end

  function automatic bit late(input int c);
    return c > tgt;
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset();
    n_tests++;
    if ({o_dly_sel, o_busy, o_lock, o_sat} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset state: got code=%h busy=%b lock=%b sat=%b",
               o_dly_sel, o_busy, o_lock, o_sat);
    end
  endtask

  task automatic tick(input int code, input bit busy, input bit lock, input bit sat, input bit pd);
    exp_t e;
    i_pd_late = pd;
    e = '{code: 8'(code), busy: busy, lock: lock, sat: sat};
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  // Rest of a trial after its first edge: detector is don't-care, starts ignored.
  task automatic hold(input int code, input bit busy, input bit lock, input bit sat, input bit poke);
    for (int k = 0; k < P_SETTLE; k++) begin
      i_start = poke ? rbit() : 1'b0;
      tick(code, busy, lock, sat, rbit());
    end
    i_start = 1'b0;
  endtask

  task automatic idle(input int n);
    i_start = 1'b0;
    for (int k = 0; k < n; k++) tick(m_code, 1'b0, 1'b0, 1'b0, rbit());
  endtask

  task automatic drop_en();
    i_en    = 1'b0;
    i_start = rbit();
    tick(m_code, 1'b0, 1'b0, 1'b0, rbit());
    i_en    = 1'b1;
    i_start = 1'b0;
    m_lock  = 1'b0;
    m_sat   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    for (int k = 0; k < n; k++) tick(0, 1'b0, 1'b0, 1'b0, rbit());
    i_rst  = 1'b0;
    m_code = 0;
    m_lock = 1'b0;
    m_sat  = 1'b0;
    check_reset();
  endtask

  // Binary search for the largest code not reported late; abort_bit < 0 runs to completion.
  task automatic search(input int abort_bit);
    int r, trial, nxt;
    bit l;
    i_start = 1'b1;
    tick(8'h80, 1'b1, 1'b0, 1'b0, rbit());
    i_start = 1'b0;
    r = 0;
    for (int b = 7; b >= 0; b--) begin
      trial = r + (1 << b);
      if (b == abort_bit) begin
        tick(trial, 1'b1, 1'b0, 1'b0, rbit());
        tick(trial, 1'b1, 1'b0, 1'b0, rbit());
        m_code = trial;
        drop_en();
        return;
      end
      hold(trial, 1'b1, 1'b0, 1'b0, 1'b1);
      l = late(trial);
      if (!l) r = trial;
      nxt = (b > 0) ? r + (1 << (b - 1)) : r;
      tick(nxt, 1'b1, 1'b0, 1'b0, l);
    end
    m_code   = r;
    m_lock   = 1'b0;
    m_sat    = 1'b0;
    has_prev = 1'b0;
    run      = 0;
  endtask

  // Lock = at least P_LOCK_CNT reversals at the tail of an unbroken alternating run.
  task automatic track(input int n);
    bit l, up, blk;
    for (int i = 0; i < n; i++) begin
      hold(m_code, 1'b1, m_lock, m_sat, 1'b1);
      l   = late(m_code);
      up  = !l;
      blk = up ? (m_code == 255) : (m_code == 0);
      if (blk) begin
        m_sat = 1'b1;
        run   = 1;
      end else begin
        m_code = up ? m_code + 1 : m_code - 1;
        m_sat  = 1'b0;
        run    = (has_prev && (up != prev_up)) ? run + 1 : 1;
      end
      prev_up  = up;
      has_prev = 1'b1;
      m_lock   = (run - 1) >= P_LOCK_CNT;
      tick(m_code, 1'b1, m_lock, m_sat, l);
    end
  endtask

  initial begin
    i_rst     = 1'b1;
    i_en      = 1'b0;
    i_start   = 1'b0;
    i_pd_late = 1'b0;
    tgt       = 0;
    m_code    = 0;
    run       = 0;
    m_lock    = 1'b0;
    m_sat     = 1'b0;
    has_prev  = 1'b0;
    prev_up   = 1'b0;

    do_reset(2);
    i_en = 1'b1;
    idle(50);

    // Convergence to 0x5A, dither lock, then retarget to 0x60 and relock
    tgt = 8'h5A;
    search(-1);
    track(8);
    tgt = 8'h60;
    track(20);

    do_reset(1);
    idle(3);

    // Saturation at both ends
    tgt = 255;
    search(-1);
    track(4);
    drop_en();
    idle(2);
    tgt = -1;
    search(-1);
    track(4);
    drop_en();
    idle(2);

    // Abort during SAR bit 4, then a fresh search
    tgt = 8'h5A;
    search(4);
    idle(5);
    search(-1);
    track(6);
    do_reset(1);
    idle(2);

    // Random targets
    for (int t = 0; t < 5; t++) begin
      tgt = int'($urandom_range(0, 255));
      search(-1);
      track(12);
      drop_en();
      idle(2);
    end

    repeat (2) @(posedge i_clk);
    #3;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
